// File: rtl/temp_buf_pkg.sv
// Shared types and address packing for the temp buffer address generators (write and read side).
// Define AG_TEMP_IN_TRANSPOSE_EN to pack addresses as {col,row} instead of {row,col}.
package temp_buf_pkg;

    localparam int FEATURE_BITS = 4;

    typedef logic [FEATURE_BITS-1:0]   idx_t;
    typedef logic [2*FEATURE_BITS-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } ag_state_e;

    localparam idx_t IDX_ZERO = {FEATURE_BITS{1'b0}};
    localparam idx_t IDX_ONE  = {{(FEATURE_BITS-1){1'b0}}, 1'b1};

    // Transposed packing lets the read side walk W^T row-major with no reordering.
    function automatic addr_t make_addr(input idx_t row, input idx_t col);
`ifdef AG_TEMP_IN_TRANSPOSE_EN
        return {col, row};
`else
        return {row, col};
`endif
    endfunction

endpackage

// File: rtl/ag_wrap_cnt.sv
// Single index counter: counts 0..limit and wraps to 0, flagging the wrapping increment.
module ag_wrap_cnt
    import temp_buf_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    inc,
    input  logic [FEATURE_BITS-1:0] limit,
    output logic [FEATURE_BITS-1:0] count,
    output logic                    wrap
);

    idx_t r_count;

    assign wrap  = inc && (r_count == limit);
    assign count = r_count;

    // Index register; clear takes priority over increment.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_count <= IDX_ZERO;
        end else if (clr) begin
            r_count <= IDX_ZERO;
        end else if (inc) begin
            if (wrap) begin
                r_count <= IDX_ZERO;
            end else begin
                r_count <= r_count + IDX_ONE;
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/ag_temp_in.sv
// Write-side temp buffer address generator: one row-major address per drained array element.
// Define AG_TEMP_IN_TRANSPOSE_EN for {col,row} address packing.
module ag_temp_in
    import temp_buf_pkg::*;
(
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [FEATURE_BITS-1:0]   rows_m1,
    input  logic [FEATURE_BITS-1:0]   cols_m1,
    input  logic                      in_valid,
    input  logic                      abort,
    output logic                      wr_en,
    output logic [2*FEATURE_BITS-1:0] address,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    ag_state_e r_state;
    ag_state_e w_next_state;
    idx_t      r_rows_lat;
    idx_t      r_cols_lat;
    logic      r_err;
    idx_t      w_row;
    idx_t      w_col;
    logic      w_start_acc;
    logic      w_abort_acc;
    logic      w_accept;
    logic      w_clr;
    logic      w_col_wrap;
    logic      w_last;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_abort_acc = (r_state == WRITE) && abort;
    assign w_accept    = (r_state == WRITE) && in_valid && !abort;
    assign w_clr       = w_start_acc || w_abort_acc;

    ag_wrap_cnt u_col_cnt (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clr     (w_clr),
        .inc     (w_accept),
        .limit   (r_cols_lat),
        .count   (w_col),
        .wrap    (w_col_wrap)
    );

    // Row wrap coincides with the last element, which also returns both indices to 0.
    ag_wrap_cnt u_row_cnt (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clr     (w_clr),
        .inc     (w_col_wrap),
        .limit   (r_rows_lat),
        .count   (w_row),
        .wrap    (w_last)
    );

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = WRITE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                if (abort) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = WRITE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register, latched dimensions and sticky error flag.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rows_lat <= IDX_ZERO;
            r_cols_lat <= IDX_ZERO;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start_acc) begin
                r_rows_lat <= rows_m1;
                r_cols_lat <= cols_m1;
            end
            // A stray element is an error even if it arrives alongside start.
            if (in_valid && (r_state != WRITE)) begin
                r_err <= 1'b1;
            end else if (w_start_acc) begin
                r_err <= 1'b0;
            end
        end
    end

    assign wr_en   = w_accept;
    assign address = make_addr(w_row, w_col);
    assign busy    = (r_state == WRITE);
    assign done    = (r_state == DONE);
    assign err     = r_err;

endmodule

// File: tb/tb_ag_temp_in.sv
// Directed self-checking bench for ag_temp_in (FEATURE_BITS=4); honours AG_TEMP_IN_TRANSPOSE_EN.
module tb_ag_temp_in;

    logic       sys_clk;
    logic       reset;
    logic       start;
    logic [3:0] rows_m1;
    logic [3:0] cols_m1;
    logic       in_valid;
    logic       abort;
    logic       wr_en;
    logic [7:0] address;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp;
    int n_bad;

    ag_temp_in dut (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .start    (start),
        .rows_m1  (rows_m1),
        .cols_m1  (cols_m1),
        .in_valid (in_valid),
        .abort    (abort),
        .wr_en    (wr_en),
        .address  (address),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Expected packed address for a (row, col) position, built independently of the DUT.
    function automatic logic [7:0] exp_addr(input int row, input int col);
        logic [3:0] r;
        logic [3:0] c;
        r = row[3:0];
        c = col[3:0];
`ifdef AG_TEMP_IN_TRANSPOSE_EN
        return {c, r};
`else
        return {r, c};
`endif
    endfunction

    task automatic do_start(input logic [3:0] r, input logic [3:0] c);
        @(negedge sys_clk);
        rows_m1  = r;
        cols_m1  = c;
        start    = 1'b1;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        start    = 1'b0;
        rows_m1  = 4'd0;
        cols_m1  = 4'd0;
        in_valid = 1'b0;
        abort    = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (address !== 8'h00) begin n_bad++; $display("FAIL reset_addr got=%h want=00", address); end
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err); end
    endtask

    // 2x3 matrix, back-to-back elements; start during DONE must be ignored.
    task automatic test_back_to_back;
        logic [7:0] want [6];
`ifdef AG_TEMP_IN_TRANSPOSE_EN
        want = '{8'h00, 8'h10, 8'h20, 8'h01, 8'h11, 8'h21};
`else
        want = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12};
`endif
        do_start(4'd1, 4'd2);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            #1;
            n_cmp++; if (wr_en !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_en[%0d] got=%b want=1", k, wr_en); end
            n_cmp++; if (address !== want[k]) begin n_bad++; $display("FAIL b2b_addr[%0d] got=%h want=%h", k, address, want[k]); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_early_done[%0d] got=%b want=0", k, done); end
            @(negedge sys_clk);
        end
        in_valid = 1'b0;
        start    = 1'b1;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got=%b want=1", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_fall got=%b want=0", busy); end
        n_cmp++; if (address !== 8'h00) begin n_bad++; $display("FAIL b2b_addr_clear got=%h want=00", address); end
        @(negedge sys_clk);
        start = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_pulse got=%b want=0", done); end
        @(negedge sys_clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_start_in_done got=%b want=0", busy); end
    endtask

    // Full 16x16 matrix with in_valid every other cycle.
    task automatic test_full_gaps;
        int bad_addr;
        int bad_hold;
        bad_addr = 0;
        bad_hold = 0;
        do_start(4'd15, 4'd15);
        for (int k = 0; k < 256; k++) begin
            in_valid = 1'b1;
            #1;
            if (wr_en !== 1'b1 || address !== exp_addr(k / 16, k % 16)) begin
                bad_addr++;
                if (bad_addr <= 4) $display("FAIL full_write[%0d] got=%b/%h want=1/%h", k, wr_en, address, exp_addr(k / 16, k % 16));
            end
            if (k == 255) begin
                n_cmp++; if (address !== 8'hFF) begin n_bad++; $display("FAIL full_last_addr got=%h want=ff", address); end
            end
            @(negedge sys_clk);
            in_valid = 1'b0;
            #1;
            if (k < 255) begin
                if (wr_en !== 1'b0 || address !== exp_addr((k + 1) / 16, (k + 1) % 16)) begin
                    bad_hold++;
                    if (bad_hold <= 4) $display("FAIL full_gap[%0d] got=%b/%h want=0/%h", k, wr_en, address, exp_addr((k + 1) / 16, (k + 1) % 16));
                end
                if (done !== 1'b0) begin
                    bad_hold++;
                    if (bad_hold <= 4) $display("FAIL full_early_done[%0d] got=%b want=0", k, done);
                end
                @(negedge sys_clk);
            end
        end
        n_cmp++; if (bad_addr != 0) begin n_bad++; $display("FAIL full_writes bad=%0d want=0", bad_addr); end
        n_cmp++; if (bad_hold != 0) begin n_bad++; $display("FAIL full_gaps bad=%0d want=0", bad_hold); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done got=%b want=1", done); end
        @(negedge sys_clk);
    endtask

    // Abort together with the 6th element of a 4x4 matrix.
    task automatic test_abort;
        do_start(4'd3, 4'd3);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            @(negedge sys_clk);
        end
        abort = 1'b1;
        #1;
        n_cmp++; if (address !== exp_addr(1, 1)) begin n_bad++; $display("FAIL abort_addr5 got=%h want=%h", address, exp_addr(1, 1)); end
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL abort_wr_en got=%b want=0", wr_en); end
        @(negedge sys_clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%b want=0", done); end
        n_cmp++; if (address !== 8'h00) begin n_bad++; $display("FAIL abort_addr_clr got=%h want=00", address); end
        do_start(4'd3, 4'd3);
        in_valid = 1'b1;
        #1;
        n_cmp++; if (wr_en !== 1'b1 || address !== 8'h00) begin n_bad++; $display("FAIL abort_restart got=%b/%h want=1/00", wr_en, address); end
        @(negedge sys_clk);
        in_valid = 1'b0;
        #1;
        n_cmp++; if (address !== exp_addr(0, 1)) begin n_bad++; $display("FAIL abort_restart_next got=%h want=%h", address, exp_addr(0, 1)); end
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
    endtask

    // Stray element in IDLE sets sticky err; accepted start clears it.
    task automatic test_err;
        @(negedge sys_clk);
        in_valid = 1'b1;
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL err_idle_wr_en got=%b want=0", wr_en); end
        @(negedge sys_clk);
        in_valid = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", err); end
        repeat (3) @(negedge sys_clk);
        #1;
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", err); end
        do_start(4'd0, 4'd0);
        #1;
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b want=0", err); end
        // Degenerate 1x1 matrix: first element finishes it.
        in_valid = 1'b1;
        #1;
        n_cmp++; if (wr_en !== 1'b1 || address !== 8'h00) begin n_bad++; $display("FAIL one_elem_write got=%b/%h want=1/00", wr_en, address); end
        @(negedge sys_clk);
        in_valid = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL one_elem_done got=%b want=1", done); end
        @(negedge sys_clk);
    endtask

    // Reset in the middle of a write returns to IDLE with no done.
    task automatic test_reset_mid;
        do_start(4'd2, 4'd2);
        repeat (2) begin
            in_valid = 1'b1;
            @(negedge sys_clk);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || address !== 8'h00) begin
            n_bad++; $display("FAIL reset_mid got=%b/%b/%h want=0/0/00", busy, done, address);
        end
        @(negedge sys_clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_mid_done got=%b want=0", done); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_back_to_back;
        test_full_gaps;
        test_abort;
        test_err;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
